// File: rtl/seven_segment_scan_controller.sv
// ============================================================================
// Module   : seven_segment_scan_controller
// Purpose  : Multiplexed N-digit seven-segment scanner with a tear-free shadow
//            register, ghost blanking, PWM brightness, leading-zero blanking
//            and per-digit decimal points. Optional macro SSD_BLINK_EN adds
//            per-digit blinking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    enable,
    input  logic                    lzb,
    input  logic [3:0]              brightness,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
    logic                    load_pending_q, load_pending_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fs_q, fs_d;

    logic                    w_div_wrap;
    logic                    w_idx_last;
    logic                    w_load;
    logic                    w_active;
    logic                    w_blank;
    logic                    w_blink_dark;
    logic [IDX_W-1:0]        w_msnz;
    logic [3:0]              w_digit;
    logic [6:0]              w_glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_div_wrap = (div_q == DIV_W'(SCAN_DIV - 1));
    assign w_idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign w_load     = (w_div_wrap && w_idx_last) || load_pending_q;
    assign w_digit    = shadow_q[4*idx_q +: 4];
    assign w_glyph    = hex_glyph(w_digit);

    // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 always shows.
    always_comb begin
        w_msnz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) begin
                w_msnz = IDX_W'(i);
            end
        end
    end

    assign w_blank = lzb && (idx_q > w_msnz);

`ifdef SSD_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] frame_cnt_q;
    logic            phase_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (w_div_wrap && w_idx_last) begin
            if (frame_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + BF_W'(1);
            end
        end
    end

    assign w_blink_dark = phase_q && blink_mask[idx_q];
`else
    // BLINK_FRAMES only matters with blinking built in; this term is always 0.
    assign w_blink_dark = (BLINK_FRAMES < 0);
`endif

    assign w_active = enable
                   && (div_q >= DIV_W'(BLANK_CYC))
                   && ((brightness == 4'hF) || (pwm_q < brightness))
                   && !w_blink_dark;

    always_comb begin
        div_d          = w_div_wrap ? '0 : div_q + DIV_W'(1);
        idx_d          = idx_q;
        pwm_d          = pwm_q + 4'd1;
        shadow_d       = shadow_q;
        dp_shadow_d    = dp_shadow_q;
        load_pending_d = load_pending_q;
        fs_d           = (div_q == '0) && (idx_q == '0);
        seg_d          = 7'h7F;
        dp_d           = 1'b1;
        an_d           = '1;

        if (w_div_wrap) begin
            idx_d = w_idx_last ? '0 : idx_q + IDX_W'(1);
        end
        if (w_load) begin
            shadow_d       = number;
            dp_shadow_d    = dp_mask;
            load_pending_d = 1'b0;
        end
        if (w_active) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = w_blank ? 7'h7F : w_glyph;
            dp_d  = ~dp_shadow_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q          <= '0;
            idx_q          <= '0;
            pwm_q          <= 4'd0;
            shadow_q       <= '0;
            dp_shadow_q    <= '0;
            load_pending_q <= 1'b1;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            an_q           <= '1;
            fs_q           <= 1'b0;
        end else begin
            div_q          <= div_d;
            idx_q          <= idx_d;
            pwm_q          <= pwm_d;
            shadow_q       <= shadow_d;
            dp_shadow_q    <= dp_shadow_d;
            load_pending_q <= load_pending_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
            fs_q           <= fs_d;
        end
    end

    assign seg_n       = seg_q;
    assign dp_n        = dp_q;
    assign an_n        = an_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
// ============================================================================
// Module   : tb_seven_segment_scan_controller
// Purpose  : Directed self-checking bench for the seven-segment scanner
//            (4 digits, 8 cycles per slot, 1 blank cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] number;
    logic [3:0]  dp_mask;
    logic        enable;
    logic        lzb;
    logic [3:0]  brightness;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .number      (number),
        .dp_mask     (dp_mask),
        .enable      (enable),
        .lzb         (lzb),
        .brightness  (brightness),
`ifdef SSD_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        reset      = 1'b0;
        number     = 16'h1234;
        dp_mask    = 4'b0000;
        enable     = 1'b1;
        lzb        = 1'b0;
        brightness = 4'hF;
        blink_mask = 4'b0000;

        // Reset held for three clocks
        repeat (3) tick();
        check("rst_an",  an_n, 4'b1111);
        check("rst_seg", seg_n, 7'h7F);
        check("rst_dp",  dp_n, 1'b1);
        check("rst_fs",  frame_start, 1'b0);

        reset = 1'b1;
        cyc   = 0;

        // First frame after release, number 1234
        run_to(1);
        check("t1_fs",     frame_start, 1'b1);
        check("t1_blank",  an_n, 4'b1111);
        run_to(2);
        check("t1_fs_off", frame_start, 1'b0);
        check("t1_an0",    an_n, 4'b1110);
        check("t1_seg4",   seg_n, 7'b0011001);
        run_to(10);
        check("t1_an1",    an_n, 4'b1101);
        check("t1_seg3",   seg_n, 7'b0110000);

        // Mid-frame change must wait for the next frame
        number = 16'hABCD;
        run_to(18);
        check("t2_an2",    an_n, 4'b1011);
        check("t2_seg2",   seg_n, 7'b0100100);
        run_to(26);
        check("t2_an3",    an_n, 4'b0111);
        check("t2_seg1",   seg_n, 7'b1111001);
        run_to(32);
        check("t2_fs_pre", frame_start, 1'b0);
        run_to(33);
        check("t2_fs",     frame_start, 1'b1);
        run_to(34);
        check("t2_segD",   seg_n, 7'b0100001);
        check("t2_anD",    an_n, 4'b1110);
        run_to(42);
        check("t2_segC",   seg_n, 7'b1000110);
        run_to(50);
        check("t2_segb",   seg_n, 7'b0000011);
        run_to(58);
        check("t2_segA",   seg_n, 7'b0001000);
        check("t2_anA",    an_n, 4'b0111);

        // Leading-zero blanking
        lzb    = 1'b1;
        number = 16'h0050;
        run_to(66);
        check("t3_seg0",   seg_n, 7'b1000000);
        check("t3_an0",    an_n, 4'b1110);
        run_to(74);
        check("t3_seg5",   seg_n, 7'b0010010);
        run_to(82);
        check("t3_an2",    an_n, 4'b1011);
        check("t3_blank2", seg_n, 7'h7F);
        run_to(90);
        check("t3_blank3", seg_n, 7'h7F);
        number = 16'h0000;
        run_to(98);
        check("t3_zero",   seg_n, 7'b1000000);
        check("t3_zan",    an_n, 4'b1110);
        run_to(106);
        check("t3_zblank", seg_n, 7'h7F);

        // PWM brightness 4: output at cycle k reflects div/idx/pwm of cycle k-1
        brightness = 4'd4;
        run_to(128);
        for (int k = 129; k <= 160; k++) begin
            int s;
            logic [3:0] exp_an;
            run_to(k);
            s = k - 1;
            exp_an = ((s % 8) >= 1 && (s % 16) < 4) ? ~(4'b0001 << ((s / 8) % 4)) : 4'b1111;
            check("t4_pwm4", an_n, exp_an);
        end
        brightness = 4'd0;
        for (int k = 161; k <= 176; k++) begin
            run_to(k);
            check("t4_pwm0", an_n, 4'b1111);
        end

        // Decimal point on digit 2 and slot-start blanking
        brightness = 4'hF;
        lzb        = 1'b0;
        dp_mask    = 4'b0100;
        run_to(193);
        check("t5_b0",     an_n, 4'b1111);
        run_to(194);
        check("t5_dp0",    dp_n, 1'b1);
        check("t5_seg0",   seg_n, 7'b1000000);
        run_to(201);
        check("t5_b1",     an_n, 4'b1111);
        run_to(209);
        check("t5_b2",     an_n, 4'b1111);
        check("t5_b2dp",   dp_n, 1'b1);
        run_to(210);
        check("t5_dp2",    dp_n, 1'b0);
        check("t5_an2",    an_n, 4'b1011);
        run_to(217);
        check("t5_b3",     an_n, 4'b1111);
        run_to(218);
        check("t5_dp3",    dp_n, 1'b1);
        check("t5_an3",    an_n, 4'b0111);

        // Enable gating takes effect on the next registered cycle
        run_to(219);
        enable = 1'b0;
        run_to(220);
        check("en_off_an",  an_n, 4'b1111);
        check("en_off_seg", seg_n, 7'h7F);
        enable = 1'b1;
        run_to(221);
        check("en_on_an",   an_n, 4'b0111);

        // Asynchronous reset in the middle of slot 2
        run_to(243);
        check("t6_pre_an", an_n, 4'b1011);
        check("t6_pre_dp", dp_n, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_an",  an_n, 4'b1111);
        check("t6_async_seg", seg_n, 7'h7F);
        check("t6_async_dp",  dp_n, 1'b1);
        repeat (2) tick();
        number  = 16'h5678;
        dp_mask = 4'b0000;
        reset   = 1'b1;
        cyc     = 0;
        run_to(1);
        check("t6_fs",     frame_start, 1'b1);
        run_to(2);
        check("t6_an0",    an_n, 4'b1110);
        check("t6_seg8",   seg_n, 7'b0000000);
        run_to(10);
        check("t6_seg7",   seg_n, 7'b1111000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
